// File: rtl/shift_writeback_pkg.sv
// rtl/shift_writeback_pkg.sv - shared shifter/writeback types and constants
package shift_writeback_pkg;

   // Widest datapath and register index a writeback entry can carry
   localparam int WB_MAX_DATA_W = 32;
   localparam int WB_MAX_RD_W   = 8;

   // Shift opcode constants used by the shifter stage
   localparam logic [1:0] SHIFT_OP_LSL = 2'd0;
   localparam logic [1:0] SHIFT_OP_LSR = 2'd1;
   localparam logic [1:0] SHIFT_OP_ASR = 2'd2;
   localparam logic [1:0] SHIFT_OP_ROR = 2'd3;

   // One queued shifter result awaiting commit
   typedef struct packed {
      logic [WB_MAX_DATA_W-1:0] data;
      logic                     c;
      logic                     z;
      logic [WB_MAX_RD_W-1:0]   rd;
      logic                     rf_we;
      logic                     flag_we;
   } wb_entry_t;

   // Writeback queue occupancy
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/shift_writeback_wb_queue2.sv
// rtl/shift_writeback_wb_queue2.sv - two-entry in-order writeback queue
module wb_queue2
   import shift_writeback_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push_valid,
   output logic      push_ready,
   input  wb_entry_t push_entry,
   output logic      pop_valid,
   input  logic      pop_ready,
   output wb_entry_t pop_entry,
   output logic      pop_fire
);

   wb_state_t state;
   wb_state_t state_nxt;
   wb_entry_t slot0;
   wb_entry_t slot1;
   logic      push_fire;
   logic      load0;
   logic      load1;
   logic      advance;

   // Readiness comes from state alone so out_ready never reaches in_ready
   assign push_ready = (state != FULL);
   assign pop_valid  = (state != EMPTY);
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;
   assign pop_entry  = slot0;

   // State register; reset empties the queue without waiting for a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and slot-load decisions; slot0 always holds the oldest entry
   always_comb begin
      state_nxt = state;
      load0     = 1'b0;
      load1     = 1'b0;
      advance   = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (push_fire) begin
                  state_nxt = ONE;
                  load0     = 1'b1;
               end
            end
            ONE: begin
               if (push_fire && pop_fire) begin
                  load0 = 1'b1;
               end else if (push_fire) begin
                  state_nxt = FULL;
                  load1     = 1'b1;
               end else if (pop_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (pop_fire) begin
                  state_nxt = ONE;
                  advance   = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Entry storage, written unmodified from the push side
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         if (load0) begin
            slot0 <= push_entry;
         end else if (advance) begin
            slot0 <= slot1;
         end
         if (load1) begin
            slot1 <= push_entry;
         end
      end
   end

endmodule

// File: rtl/shift_writeback.sv
// rtl/shift_writeback.sv - shifter result writeback with committed flags
module shift_writeback
   import shift_writeback_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RD_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_c,
   input  logic              in_z,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_rf_we,
   input  logic              in_flag_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_rf_we,
   output logic              flag_c,
   output logic              flag_z
);

   wb_entry_t in_entry;
   wb_entry_t head;
   logic      pop_fire;
   logic      unused_head;

   // Pack the incoming result into a zero-extended queue entry
   always_comb begin
      in_entry                 = '0;
      in_entry.data[DATA_W-1:0] = in_data;
      in_entry.c               = in_c;
      in_entry.z               = in_z;
      in_entry.rd[RD_W-1:0]    = in_rd;
      in_entry.rf_we           = in_rf_we;
      in_entry.flag_we         = in_flag_we;
   end

   wb_queue2 u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_entry (in_entry),
      .pop_valid  (out_valid),
      .pop_ready  (out_ready),
      .pop_entry  (head),
      .pop_fire   (pop_fire)
   );

   assign out_data  = head.data[DATA_W-1:0];
   assign out_rd    = head.rd[RD_W-1:0];
   assign out_rf_we = head.rf_we;

   // Upper bits of the wide entry are zero padding when the block is narrower
   assign unused_head = ^{head.data, head.rd};

   // Architectural flags change only when a flag-writing entry commits, never during flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else if (pop_fire && !flush && head.flag_we) begin
         flag_c <= head.c;
         flag_z <= head.z;
      end
   end

endmodule

// File: tb/tb_shift_writeback.sv
// tb/tb_shift_writeback.sv - scoreboard bench for shift_writeback
module tb_shift_writeback;

   typedef struct {
      logic [7:0] d;
      logic       c;
      logic       z;
      logic [2:0] rd;
      logic       rfwe;
      logic       fwe;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       in_c = 1'b0;
   logic       in_z = 1'b0;
   logic [2:0] in_rd = '0;
   logic       in_rf_we = 1'b0;
   logic       in_flag_we = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [2:0] out_rd;
   logic       out_rf_we;
   logic       flag_c;
   logic       flag_z;

   int   checks = 0;
   int   errors = 0;
   ent_t sb[$];
   logic exp_c = 1'b0;
   logic exp_z = 1'b0;
   logic pend_push = 1'b0;
   logic pend_flush = 1'b0;
   ent_t pend_ent;
   logic mon_en = 1'b0;

   shift_writeback #(.DATA_W(8), .RD_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_c       (in_c),
      .in_z       (in_z),
      .in_rd      (in_rd),
      .in_rf_we   (in_rf_we),
      .in_flag_we (in_flag_we),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_rd     (out_rd),
      .out_rf_we  (out_rf_we),
      .flag_c     (flag_c),
      .flag_z     (flag_z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic [7:0] d, input logic c, input logic z,
                               input logic [2:0] rd, input logic rfwe, input logic fwe);
      ent_t e;
      e.d = d; e.c = c; e.z = z; e.rd = rd; e.rfwe = rfwe; e.fwe = fwe;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      return mk(8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom));
   endfunction

   task automatic set_inputs(input logic v, input ent_t e, input logic ordy, input logic fl);
      in_valid   = v;
      in_data    = e.d;
      in_c       = e.c;
      in_z       = e.z;
      in_rd      = e.rd;
      in_rf_we   = e.rfwe;
      in_flag_we = e.fwe;
      out_ready  = ordy;
      flush      = fl;
   endtask

   // One cycle: commit what the last edge did to the model, then offer new inputs
   task automatic cyc(input logic v, input ent_t e, input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      if (pend_flush) sb.delete();
      else if (pend_push) sb.push_back(pend_ent);
      set_inputs(v, e, ordy, fl);
      pend_push  = v && (sb.size() < 2) && !fl;
      pend_flush = fl;
      pend_ent   = e;
   endtask

   // Monitor: compare outputs with the model, retire the head when it is consumed
   initial begin
      ent_t h;
      forever begin
         @(negedge clk);
         if (rst_n && mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
            if (sb.size() != 0) begin
               h = sb[0];
               chk("out_data", 32'(out_data), 32'(h.d));
               chk("out_rd", 32'(out_rd), 32'(h.rd));
               chk("out_rf_we", 32'(out_rf_we), 32'(h.rfwe));
            end
            chk("flag_c", 32'(flag_c), 32'(exp_c));
            chk("flag_z", 32'(flag_z), 32'(exp_z));
            if (sb.size() != 0 && out_ready && !flush) begin
               h = sb.pop_front();
               if (h.fwe) begin
                  exp_c = h.c;
                  exp_z = h.z;
               end
            end
         end
      end
   end

   initial begin
      ent_t idle;
      ent_t e;
      idle = mk(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      // Reset values, with the first push already offered
      e = mk(8'h81, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1);
      set_inputs(1'b1, e, 1'b1, 1'b0);
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_rf_we", 32'(out_rf_we), 32'd0);
      chk("rst_flags", 32'({flag_c, flag_z}), 32'd0);
      @(negedge clk);
      #2;
      rst_n      = 1'b1;
      mon_en     = 1'b1;
      pend_push  = 1'b1;
      pend_flush = 1'b0;
      pend_ent   = e;

      // Single entry commits and loads carry
      cyc(1'b0, idle, 1'b1, 1'b0);
      cyc(1'b0, idle, 1'b1, 1'b0);
      chk("flag_c_after_81", 32'(flag_c), 32'd1);

      // Three back-to-back pushes into a stalled consumer, long stall, then drain
      cyc(1'b1, mk(8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h22, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, mk(8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, idle, 1'b1, 1'b0);
      chk("flag_z_before_zero", 32'(flag_z), 32'd0);

      // Zero result without flag write leaves Z alone
      cyc(1'b1, mk(8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, idle, 1'b1, 1'b0);
      chk("flag_z_kept", 32'(flag_z), 32'd0);

      // Flush while full with simultaneous pop and push
      cyc(1'b1, mk(8'h44, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h55, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h66, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, idle, 1'b1, 1'b0);
      chk("flush_empty", 32'(out_valid), 32'd0);

      // Asynchronous reset while one entry is queued
      cyc(1'b1, mk(8'h77, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1), 1'b1, 1'b0);
      cyc(1'b0, idle, 1'b1, 1'b0);
      cyc(1'b0, idle, 1'b1, 1'b0);
      cyc(1'b1, mk(8'h99, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1), 1'b0, 1'b0);
      cyc(1'b0, idle, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_flags", 32'({flag_c, flag_z}), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd1);
      chk("async_rst_flags", 32'({flag_c, flag_z}), 32'd0);
      sb.delete();
      exp_c = 1'b0;
      exp_z = 1'b0;
      e = mk(8'hA5, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
      set_inputs(1'b1, e, 1'b0, 1'b0);
      pend_push  = 1'b1;
      pend_flush = 1'b0;
      pend_ent   = e;
      @(negedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), rnd_ent(), 1'($urandom), 1'($urandom_range(0, 19) == 0));
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_writeback.md
SHIFT_WRITEBACK -- requirements
Module: shift_writeback

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the result datapath width.
REQ-002 Parameter RD_W, default 3, SHALL set the destination-register index width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be a synchronous discard of all queued entries.
REQ-006 in_valid  input  1  SHALL mark a shifter result offered this cycle.
REQ-007 in_ready  output  1  SHALL indicate the block can accept an entry this cycle.
REQ-008 in_data  input  DATA_W  SHALL carry the shifter shift_out value.
REQ-009 in_c, in_z  input  1 each  SHALL carry the shifter carry and zero outputs.
REQ-010 in_rd  input  RD_W  SHALL carry the destination register index.
REQ-011 in_rf_we, in_flag_we  input  1 each  SHALL request a register-file write and a flag update.
REQ-012 out_valid  output  1  SHALL mark a committed entry presented to the register file.
REQ-013 out_ready  input  1  SHALL indicate the register file consumes the entry this cycle.
REQ-014 out_data, out_rd, out_rf_we  output  DATA_W, RD_W, 1  SHALL carry the head entry.
REQ-015 flag_c, flag_z  output  1 each  SHALL be the architectural carry and zero flags.

Function
REQ-016 Storage SHALL be a 2-entry in-order queue; FSM states are EMPTY, ONE, FULL.
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL be derived only from state (no combinational path from out_ready).
REQ-019 out_valid SHALL be 1 exactly in ONE and FULL; out_* SHALL reflect the oldest entry.
REQ-020 Latency: an entry pushed at edge N SHALL appear on out_* no earlier than after edge N (cycle N+1); there is no combinational in-to-out bypass.
REQ-021 Transitions: EMPTY+push->ONE; ONE+push-pop->FULL; ONE+pop-push->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; all other combinations SHALL hold state.
REQ-022 While out_valid && !out_ready, out_data, out_rd and out_rf_we SHALL remain stable.
REQ-023 On pop of an entry with flag_we=1, flag_c and flag_z SHALL load that entry's c and z at the same edge; entries with flag_we=0 SHALL leave the flags unchanged.
REQ-024 Flags SHALL never update on push; they update only on commit (pop).
REQ-025 flush=1 SHALL force state to EMPTY at the next edge, discarding queued entries and any simultaneous push; the flags SHALL NOT change, even if a pop occurs in the same cycle.
REQ-026 Entry fields SHALL be stored unmodified; the block SHALL NOT recompute Z from data.

Reset
REQ-027 While rst_n=0, state SHALL be EMPTY, so in_ready=1, out_valid=0, out_data=0, out_rd=0, out_rf_we=0, flag_c=0, flag_z=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-029 The first push SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-030 The queue-entry struct (data, c, z, rd, rf_we, flag_we) and the FSM state enum SHALL live in the shared processor package, alongside the shift opcode constants.
REQ-031 The 2-entry queue SHALL be the sub-module wb_queue2; flag-register logic SHALL stay in shift_writeback.

Verification
REQ-032 Push data=8'h81, c=1, z=0, flag_we=1 with out_ready=1 -> out_valid in the next cycle, out_data=8'h81; flag_c=1 after the pop edge.
REQ-033 Push 3 entries back-to-back with out_ready=0 -> in_ready=0 after the 2nd push; the 3rd is held; releasing out_ready pops them in order.
REQ-034 Hold out_ready=0 for 5 cycles in FULL -> out_* stable every cycle, flags unchanged.
REQ-035 Pop data=8'h00, z=1, flag_we=0 -> flag_z keeps its prior value 0.
REQ-036 In FULL, assert flush together with pop and push -> EMPTY next cycle, flags unchanged, no entry emitted.
REQ-037 Drop rst_n between clock edges while in ONE -> out_valid=0 and flags=0 immediately.
